mips_trace_checker: RTL
=======================

Name: mips_trace_checker

Overview:
- Hardware trace checker that consumes the per-cycle observation stream a 16-bit MIPS processor emits (pc_out, alu_result) and compares it against a preloaded expected trace.
- Sits beside mips_processor in simulation and FPGA bring-up, replacing manual $display inspection with registered pass/fail/hang verdicts and first-failure capture.

Parameters:
PC_WIDTH, 16, width of program-counter samples
DATA_WIDTH, 16, width of ALU-result samples
TRACE_DEPTH, 16, number of expected-trace entries (power of 2, >=2); IDX_W = $clog2(TRACE_DEPTH)
HANG_LIMIT, 8, consecutive identical-PC samples that declare a hang (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
exp_wr_en  input  1  write one expected-trace entry
exp_wr_addr  input  IDX_W  entry index to write
exp_wr_pc  input  PC_WIDTH  expected PC for entry
exp_wr_result  input  DATA_WIDTH  expected ALU result for entry
trace_len  input  IDX_W+1  number of entries to check (0..TRACE_DEPTH), sampled at start
start  input  1  pulse: begin checking
clear  input  1  synchronous return to IDLE from any state
sample_en  input  1  pc_in/result_in valid this cycle
pc_in  input  PC_WIDTH  observed pc_out
result_in  input  DATA_WIDTH  observed alu_result
busy  output  1  high in RUN
done  output  1  high in DONE or HANG
pass  output  1  high in DONE with zero mismatches
hang  output  1  high in HANG
mismatch_cnt  output  IDX_W+1  mismatching samples, saturating
fail_idx  output  IDX_W  index of first mismatch
fail_pc  output  PC_WIDTH  observed PC at first mismatch
fail_result  output  DATA_WIDTH  observed result at first mismatch

Behaviour:
- rst_n low (async): state IDLE; all outputs, idx, counters, captured fields = 0. Trace RAM contents not reset.
- States: IDLE, RUN, DONE, HANG. clear has priority over all transitions -> IDLE, counters/flags/fail fields zeroed; RAM kept.
- Trace RAM writes: accepted only in IDLE; ignored in RUN/DONE/HANG. Write and start in same cycle: write commits; first compare no earlier than next cycle, so entry is visible.
- IDLE + start: latch trace_len; idx=0, mismatch_cnt=0, same-PC count=0. trace_len==0 -> DONE directly, pass=1. Otherwise -> RUN. start ignored outside IDLE.
- RUN, sample_en=1: compare pc_in/result_in against entry[idx] (both fields must match). Mismatch -> mismatch_cnt+1, saturating at all-ones; on first mismatch only, capture fail_idx=idx, fail_pc, fail_result. idx+1.
- Sample at idx==latched_len-1 -> DONE next cycle; pass = (final mismatch_cnt==0), including the last sample's result.
- Hang: count consecutive samples with pc_in equal to previous sampled pc_in; the first sample of a run never counts. When count reaches HANG_LIMIT-1 repeats (HANG_LIMIT identical samples total) -> HANG; that sample is still compared and counted. If hang and last-entry completion coincide, HANG wins; pass=0.
- RUN, sample_en=0: no change; cycles without samples do not advance the hang counter.
- Latency: all outputs registered; verdict and counters visible one cycle after the deciding sample.
- DONE/HANG hold until clear or reset. pass=0 in HANG, RUN, IDLE.

Test Plan:
- Load 4 entries (pc 0,2,4,6; results 5,0,9,3), trace_len=4, start, feed matching stream -> busy 4 cycles, done=1, pass=1, mismatch_cnt=0.
- Same trace, entry 2 observed result 8 and entry 3 pc 7 -> done=1, pass=0, mismatch_cnt=2, fail_idx=2, fail_pc=4, fail_result=8.
- HANG_LIMIT=8, trace_len=16, pc_in held at 10 for 8 samples -> hang=1, done=1, pass=0 after 8th sample; exp_wr_en then ignored.
- trace_len=0, start -> done=1, pass=1 next cycle; sample_en pulses have no effect; clear -> all outputs 0.
- Mid-RUN async rst_n low -> all outputs 0 immediately. Re-start after reset -> RAM contents retained and full pass.
- TRACE_DEPTH=4 all mismatching, with sample_en gaps between samples -> mismatch_cnt=4, no saturation wrap; gaps cause no index advance and no hang.

Source files
------------

// File: rtl/mips_trace_checker.sv
`default_nettype none
// ============================================================================
// Module      : mips_trace_checker
// Description : Compares the per-cycle (pc, alu_result) observation stream of
//               a 16-bit MIPS core against a preloaded expected trace, giving
//               registered pass / fail / hang verdicts and first-failure capture.
// Ports       : clk, rst_n              - clock, async active-low reset
//               exp_wr_*                - expected-trace RAM write (IDLE only)
//               trace_len, start, clear - run control
//               sample_en, pc_in, result_in - observed stream
//               busy, done, pass, hang  - verdict flags
//               mismatch_cnt, fail_*    - error count and first-failure data
// Revision    : 1.0 - initial release
// ============================================================================
module mips_trace_checker #(
   parameter  int PC_WIDTH    = 16,
   parameter  int DATA_WIDTH  = 16,
   parameter  int TRACE_DEPTH = 16,
   parameter  int HANG_LIMIT  = 8,
   localparam int IDX_W       = $clog2(TRACE_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  exp_wr_en,
   input  logic [IDX_W-1:0]      exp_wr_addr,
   input  logic [PC_WIDTH-1:0]   exp_wr_pc,
   input  logic [DATA_WIDTH-1:0] exp_wr_result,
   input  logic [IDX_W:0]        trace_len,
   input  logic                  start,
   input  logic                  clear,
   input  logic                  sample_en,
   input  logic [PC_WIDTH-1:0]   pc_in,
   input  logic [DATA_WIDTH-1:0] result_in,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  hang,
   output logic [IDX_W:0]        mismatch_cnt,
   output logic [IDX_W-1:0]      fail_idx,
   output logic [PC_WIDTH-1:0]   fail_pc,
   output logic [DATA_WIDTH-1:0] fail_result
);

   localparam int c_same_w = $clog2(HANG_LIMIT);

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_run  = 2'd1;
   localparam logic [1:0] c_st_done = 2'd2;
   localparam logic [1:0] c_st_hang = 2'd3;

   logic [1:0]            r_state;
   logic [1:0]            w_state_nxt;

   logic [PC_WIDTH-1:0]   r_exp_pc  [TRACE_DEPTH];
   logic [DATA_WIDTH-1:0] r_exp_res [TRACE_DEPTH];

   logic [IDX_W:0]        r_len;
   logic [IDX_W-1:0]      r_idx;
   logic [IDX_W:0]        r_mis;
   logic [IDX_W-1:0]      r_fail_idx;
   logic [PC_WIDTH-1:0]   r_fail_pc;
   logic [DATA_WIDTH-1:0] r_fail_res;
   logic [PC_WIDTH-1:0]   r_prev_pc;
   logic                  r_have_prev;
   logic [c_same_w-1:0]   r_same_cnt;

   logic                  w_sample;
   logic                  w_match;
   logic                  w_last;
   logic                  w_repeat;
   logic [c_same_w-1:0]   w_same_nxt;
   logic                  w_hang_hit;

   // Only accepted samples in RUN participate in checking.
   assign w_sample   = (r_state == c_st_run) && sample_en;
   assign w_match    = (pc_in == r_exp_pc[r_idx]) && (result_in == r_exp_res[r_idx]);
   assign w_last     = ({1'b0, r_idx} == (r_len - 1'b1));
   // First sample after start has no predecessor, so it can never be a repeat.
   assign w_repeat   = r_have_prev && (pc_in == r_prev_pc);
   assign w_same_nxt = w_repeat ? (r_same_cnt + 1'b1) : '0;
   assign w_hang_hit = w_same_nxt == c_same_w'(HANG_LIMIT - 1);

   // Expected-trace RAM; contents survive reset and clear.
   always_ff @(posedge clk) begin
      if (exp_wr_en && (r_state == c_st_idle)) begin
         r_exp_pc[exp_wr_addr]  <= exp_wr_pc;
         r_exp_res[exp_wr_addr] <= exp_wr_result;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= c_st_idle;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = c_st_idle;
      end else begin
         case (r_state)
            c_st_idle: if (start) w_state_nxt = (trace_len == '0) ? c_st_done : c_st_run;
            c_st_run: begin
               if (w_sample) begin
                  // A hang on the final sample outranks normal completion.
                  if (w_hang_hit)  w_state_nxt = c_st_hang;
                  else if (w_last) w_state_nxt = c_st_done;
               end
            end
            default: w_state_nxt = r_state;
         endcase
      end
   end

   // Output decode (all sources are registers)
   always_comb begin
      busy = (r_state == c_st_run);
      done = (r_state == c_st_done) || (r_state == c_st_hang);
      pass = (r_state == c_st_done) && (r_mis == '0);
      hang = (r_state == c_st_hang);
   end

   assign mismatch_cnt = r_mis;
   assign fail_idx     = r_fail_idx;
   assign fail_pc      = r_fail_pc;
   assign fail_result  = r_fail_res;

   // Checking datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len       <= '0;
         r_idx       <= '0;
         r_mis       <= '0;
         r_fail_idx  <= '0;
         r_fail_pc   <= '0;
         r_fail_res  <= '0;
         r_prev_pc   <= '0;
         r_have_prev <= 1'b0;
         r_same_cnt  <= '0;
      end else if (clear || ((r_state == c_st_idle) && start)) begin
         r_len       <= clear ? '0 : trace_len;
         r_idx       <= '0;
         r_mis       <= '0;
         r_fail_idx  <= '0;
         r_fail_pc   <= '0;
         r_fail_res  <= '0;
         r_prev_pc   <= '0;
         r_have_prev <= 1'b0;
         r_same_cnt  <= '0;
      end else if (w_sample) begin
         if (!w_match) begin
            if (r_mis != '1) r_mis <= r_mis + 1'b1;
            // Capture only the first failing sample of the run.
            if (r_mis == '0) begin
               r_fail_idx <= r_idx;
               r_fail_pc  <= pc_in;
               r_fail_res <= result_in;
            end
         end
         r_idx       <= r_idx + 1'b1;
         r_prev_pc   <= pc_in;
         r_have_prev <= 1'b1;
         r_same_cnt  <= w_same_nxt;
      end
   end

endmodule
`default_nettype wire
